// File: rtl/tlul_sram_slave_if.sv
// ============================================================================
//  Module   : tlul_sram_slave_if
//  Purpose  : TL-UL A/D channel bundle between a requester and the SRAM slave
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tlul_sram_slave_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int SIZE_WIDTH   = 3,
    parameter int SRC_WIDTH    = 4,
    parameter int SINK_WIDTH   = 1,
    parameter int OPCODE_WIDTH = 3,
    parameter int PARAM_WIDTH  = 3
);
    // A channel
    logic                    a_valid;
    logic                    a_ready;
    logic [OPCODE_WIDTH-1:0] a_opcode;
    logic [PARAM_WIDTH-1:0]  a_param;
    logic [SIZE_WIDTH-1:0]   a_size;
    logic [SRC_WIDTH-1:0]    a_source;
    logic [ADDR_WIDTH-1:0]   a_address;
    logic [MASK_WIDTH-1:0]   a_mask;
    logic [DATA_WIDTH-1:0]   a_data;
    // D channel
    logic                    d_valid;
    logic                    d_ready;
    logic [OPCODE_WIDTH-1:0] d_opcode;
    logic [PARAM_WIDTH-1:0]  d_param;
    logic [SIZE_WIDTH-1:0]   d_size;
    logic [SRC_WIDTH-1:0]    d_source;
    logic [SINK_WIDTH-1:0]   d_sink;
    logic [DATA_WIDTH-1:0]   d_data;
    logic                    d_error;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
    );
endinterface

`default_nettype wire

// File: rtl/tlul_sram_slave.sv
// ============================================================================
//  Module   : tlul_sram_slave
//  Purpose  : TL-UL slave with a small word array, one outstanding request,
//             fixed response latency and AccessAck/AccessAckData + d_error
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlul_sram_slave #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int                    SIZE_WIDTH   = 3,
    parameter int                    SRC_WIDTH    = 4,
    parameter int                    SINK_WIDTH   = 1,
    parameter int                    OPCODE_WIDTH = 3,
    parameter int                    PARAM_WIDTH  = 3,
    parameter int                    MEM_DEPTH    = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_1000,
    parameter int                    RESP_LATENCY = 2
) (
    input  wire logic        clk_24,
    input  wire logic        reset,
    tlul_sram_slave_if.slave bus
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [3:0] LAT_LOAD = (RESP_LATENCY > 0) ? 4'(RESP_LATENCY - 1) : 4'd0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PART = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_GET      = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ACK      = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_ACK_DATA = OPCODE_WIDTH'(1);

    logic [1:0]              state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    rdy_en_q, rdy_en_d;
    logic                    d_valid_q, d_valid_d;
    logic [OPCODE_WIDTH-1:0] d_opcode_q, d_opcode_d;
    logic [SIZE_WIDTH-1:0]   d_size_q, d_size_d;
    logic [SRC_WIDTH-1:0]    d_source_q, d_source_d;
    logic [DATA_WIDTH-1:0]   d_data_q, d_data_d;
    logic                    d_error_q, d_error_d;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0]   w_offset;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_op_get;
    logic                    w_op_put;
    logic                    w_err;
    logic                    w_accept;
    logic                    unused_a_param;

    // a_param carries no meaning for this endpoint
    assign unused_a_param = ^bus.a_param;

    // Decode the presented request: target word and every rejection reason
    always_comb begin
        w_offset = bus.a_address - BASE_ADDR;
        w_idx    = w_offset[IDX_W+1:2];
        w_op_get = (bus.a_opcode == OP_GET);
        w_op_put = (bus.a_opcode == OP_PUT_FULL) || (bus.a_opcode == OP_PUT_PART);
        w_err    = !(w_op_get || w_op_put)
                || (bus.a_size > SIZE_WIDTH'(2))
                || ((bus.a_size == SIZE_WIDTH'(1)) && bus.a_address[0])
                || ((bus.a_size == SIZE_WIDTH'(2)) && (bus.a_address[1:0] != 2'b00))
                || (bus.a_address < BASE_ADDR)
                || ((w_offset >> 2) >= ADDR_WIDTH'(MEM_DEPTH));
    end

    // rdy_en_q holds a_ready low until the first clock after reset release
    assign bus.a_ready  = rdy_en_q && (state_q == ST_IDLE);
    assign w_accept     = bus.a_valid && bus.a_ready;

    assign bus.d_valid  = d_valid_q;
    assign bus.d_opcode = d_opcode_q;
    assign bus.d_param  = '0;
    assign bus.d_size   = d_size_q;
    assign bus.d_source = d_source_q;
    assign bus.d_sink   = '0;
    assign bus.d_data   = d_data_q;
    assign bus.d_error  = d_error_q;

    // Request acceptance, memory commit, latency countdown and response handshake
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdy_en_d   = 1'b1;
        d_valid_d  = d_valid_q;
        d_opcode_d = d_opcode_q;
        d_size_d   = d_size_q;
        d_source_d = d_source_q;
        d_data_d   = d_data_q;
        d_error_d  = d_error_q;
        mem_d      = mem_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    // Response fields are frozen here, so they stay stable through RESP
                    d_opcode_d = w_op_get ? OP_ACK_DATA : OP_ACK;
                    d_size_d   = bus.a_size;
                    d_source_d = bus.a_source;
                    d_error_d  = w_err;
                    d_data_d   = (w_op_get && !w_err) ? mem_q[w_idx] : '0;
                    if (w_op_put && !w_err) begin
                        for (int b = 0; b < MASK_WIDTH; b++) begin
                            if (bus.a_mask[b]) begin
                                mem_d[w_idx][8*b +: 8] = bus.a_data[8*b +: 8];
                            end
                        end
                    end
                    if (RESP_LATENCY > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                // d_valid is raised from a flop one cycle into RESP
                if (!d_valid_q) begin
                    d_valid_d = 1'b1;
                end else if (bus.d_ready) begin
                    d_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, response and array registers; reset clears everything including memory
    always_ff @(posedge clk_24 or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            rdy_en_q   <= 1'b0;
            d_valid_q  <= 1'b0;
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_data_q   <= '0;
            d_error_q  <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdy_en_q   <= rdy_en_d;
            d_valid_q  <= d_valid_d;
            d_opcode_q <= d_opcode_d;
            d_size_q   <= d_size_d;
            d_source_q <= d_source_d;
            d_data_q   <= d_data_d;
            d_error_q  <= d_error_d;
            mem_q      <= mem_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tlul_sram_slave.sv
// ============================================================================
//  Module   : tb_tlul_sram_slave
//  Purpose  : Self-checking bench for tlul_sram_slave: directed scenarios plus
//             random traffic against a transaction-level reference model
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tlul_sram_slave;
    localparam int          LAT   = 2;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic clk_24;
    logic rst_n;

    tlul_sram_slave_if bus ();

    tlul_sram_slave #(
        .MEM_DEPTH    (DEPTH),
        .BASE_ADDR    (BASE),
        .RESP_LATENCY (LAT)
    ) dut (
        .clk_24 (clk_24),
        .reset  (rst_n),
        .bus    (bus.slave)
    );

    initial clk_24 = 1'b0;
    always #5 clk_24 = ~clk_24;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int dr_mode = 0;          // 0: d_ready=1, 1: d_ready=0, 2: random

    // reference model state
    logic [31:0] m_mem [DEPTH];
    logic        m_busy;
    logic        m_rdy_ok;
    int          m_resp_at;
    logic [46:0] m_exp;

    // observations used by the literal checks
    int          acc_cyc  = 0;
    int          hs_cyc   = 0;
    int          hs_count = 0;
    int          lat_obs  = 0;
    logic        prev_valid;
    logic [46:0] last_pack;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model_err(input logic [2:0] op, input logic [2:0] sz, input logic [31:0] a);
        logic e;
        e = 1'b0;
        if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) e = 1'b1;
        if (sz > 3'd2) e = 1'b1;
        if (sz == 3'd1 && (a % 2) != 0) e = 1'b1;
        if (sz == 3'd2 && (a % 4) != 0) e = 1'b1;
        if (a < BASE || a >= BASE + 4 * DEPTH) e = 1'b1;
        return e;
    endfunction

    function automatic logic [46:0] dut_pack();
        return {bus.d_opcode, bus.d_param, bus.d_size, bus.d_source, bus.d_sink, bus.d_data, bus.d_error};
    endfunction

    initial begin
        forever begin
            @(posedge clk_24);
            cyc++;
        end
    end

    initial begin
        bus.d_ready = 1'b1;
        forever begin
            @(posedge clk_24);
            #2;
            case (dr_mode)
                0:       bus.d_ready = 1'b1;
                1:       bus.d_ready = 1'b0;
                default: bus.d_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Model and comparator: everything is sampled mid-cycle, then the model
    // advances by what the coming rising edge must do.
    initial begin
        m_busy = 1'b0; m_rdy_ok = 1'b0; m_resp_at = 0; m_exp = '0; prev_valid = 1'b0; last_pack = '0;
        forever begin
            @(negedge clk_24);
            if (!rst_n) begin
                m_busy = 1'b0;
                m_rdy_ok = 1'b0;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
                check("rst_a_ready", 64'(bus.a_ready), 64'd0);
                check("rst_d_valid", 64'(bus.d_valid), 64'd0);
                check("rst_d_fields", 64'(dut_pack()), 64'd0);
                prev_valid = 1'b0;
            end else begin
                automatic logic exp_ready = m_rdy_ok && !m_busy;
                automatic logic exp_valid = m_busy && (cyc >= m_resp_at);
                check("a_ready", 64'(bus.a_ready), 64'(exp_ready));
                check("d_valid", 64'(bus.d_valid), 64'(exp_valid));
                if (exp_valid) check("d_fields", 64'(dut_pack()), 64'(m_exp));

                if (bus.d_valid && !prev_valid) lat_obs = cyc - acc_cyc;
                prev_valid = bus.d_valid;
                if (bus.a_valid && bus.a_ready) acc_cyc = cyc + 1;
                if (bus.d_valid && bus.d_ready) begin
                    hs_cyc = cyc + 1;
                    hs_count++;
                    last_pack = dut_pack();
                end

                if (exp_valid && bus.d_ready) begin
                    m_busy = 1'b0;
                end else if (exp_ready && bus.a_valid) begin
                    automatic logic [2:0]  op  = bus.a_opcode;
                    automatic logic [31:0] a   = bus.a_address;
                    automatic logic        e   = model_err(op, bus.a_size, a);
                    automatic int          idx = int'((a - BASE) / 4);
                    automatic logic [31:0] rd  = 32'h0;
                    if (!e && (op == 3'd0 || op == 3'd1)) begin
                        for (int b = 0; b < 4; b++)
                            if (bus.a_mask[b]) m_mem[idx][8*b +: 8] = bus.a_data[8*b +: 8];
                    end
                    if (!e && op == 3'd4) rd = m_mem[idx];
                    m_exp = {(op == 3'd4) ? 3'd1 : 3'd0, 3'd0, bus.a_size, bus.a_source, 1'b0, rd, e};
                    m_busy = 1'b1;
                    m_resp_at = cyc + 1 + LAT + 1;
                end
                m_rdy_ok = 1'b1;
            end
        end
    end

    task automatic drive_a(input logic [2:0] op, input logic [31:0] addr, input logic [2:0] sz,
                           input logic [3:0] src, input logic [3:0] mask, input logic [31:0] data);
        bus.a_valid   = 1'b1;
        bus.a_opcode  = op;
        bus.a_param   = 3'($urandom_range(0, 7));
        bus.a_size    = sz;
        bus.a_source  = src;
        bus.a_address = addr;
        bus.a_mask    = mask;
        bus.a_data    = data;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [2:0] sz,
                        input logic [3:0] src, input logic [3:0] mask, input logic [31:0] data);
        logic got;
        got = 1'b0;
        @(posedge clk_24); #1;
        drive_a(op, addr, sz, src, mask, data);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_24);
            if (bus.a_ready) begin got = 1'b1; break; end
        end
        if (!got) check("accept_timeout", 64'(got), 64'd1);
        @(posedge clk_24); #1;
        bus.a_valid   = 1'b0;
        bus.a_address = $urandom;
        bus.a_data    = $urandom;
    endtask

    task automatic wait_hs();
        int n0;
        logic got;
        n0 = hs_count;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_24); #1;
            if (hs_count != n0) begin got = 1'b1; break; end
        end
        if (!got) check("resp_timeout", 64'(got), 64'd1);
    endtask

    task automatic txn(input logic [2:0] op, input logic [31:0] addr, input logic [2:0] sz,
                       input logic [3:0] src, input logic [3:0] mask, input logic [31:0] data);
        send(op, addr, sz, src, mask, data);
        wait_hs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.a_valid = 1'b0; bus.a_opcode = '0; bus.a_param = '0; bus.a_size = '0;
        bus.a_source = '0; bus.a_address = '0; bus.a_mask = '0; bus.a_data = '0;
        repeat (3) @(posedge clk_24);
        #1 rst_n = 1'b1;

        // Put then Get
        txn(3'd0, 32'h1000, 3'd2, 4'd3, 4'hF, 32'hDEADBEEF);
        check("put_latency", 64'(lat_obs), 64'd3);
        check("put_ack", 64'(last_pack), {17'd0, 3'd0, 3'd0, 3'd2, 4'd3, 1'b0, 32'h0, 1'b0});
        check("model_word0", 64'(m_mem[0]), 64'hDEADBEEF);
        txn(3'd4, 32'h1000, 3'd2, 4'd5, 4'h0, 32'h0);
        check("get_ack", 64'(last_pack), {17'd0, 3'd1, 3'd0, 3'd2, 4'd5, 1'b0, 32'hDEADBEEF, 1'b0});

        // Partial write, then empty-mask write
        txn(3'd1, 32'h1000, 3'd2, 4'd1, 4'b0101, 32'h11223344);
        txn(3'd4, 32'h1000, 3'd2, 4'd1, 4'h0, 32'h0);
        check("partial_data", 64'(last_pack[32:1]), 64'hDE22BE44);
        txn(3'd0, 32'h1000, 3'd2, 4'd2, 4'h0, 32'hFFFFFFFF);
        check("mask0_err", 64'(last_pack[0]), 64'd0);
        txn(3'd4, 32'h1000, 3'd2, 4'd2, 4'h0, 32'h0);
        check("mask0_data", 64'(last_pack[32:1]), 64'hDE22BE44);

        // Error cases
        txn(3'd4, 32'h1040, 3'd2, 4'd6, 4'h0, 32'h0);
        check("err_range", 64'({last_pack[46:44], last_pack[32:0]}), {28'd0, 3'd1, 32'h0, 1'b1});
        txn(3'd4, 32'h1002, 3'd2, 4'd6, 4'h0, 32'h0);
        check("err_misalign", 64'(last_pack[0]), 64'd1);
        txn(3'd4, 32'h0FFC, 3'd2, 4'd6, 4'h0, 32'h0);
        check("err_below", 64'(last_pack[0]), 64'd1);
        txn(3'd3, 32'h1000, 3'd2, 4'd7, 4'hF, 32'h0);
        check("err_opcode", 64'({last_pack[46:44], last_pack[32:0]}), {28'd0, 3'd0, 32'h0, 1'b1});
        txn(3'd4, 32'h1000, 3'd2, 4'd8, 4'h0, 32'h0);
        check("err_nowrite", 64'(last_pack[32:1]), 64'hDE22BE44);

        // Backpressure with a queued second request
        dr_mode = 1;
        send(3'd4, 32'h1000, 3'd2, 4'd4, 4'h0, 32'h0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk_24);
                if (bus.d_valid) begin seen = 1'b1; break; end
            end
            check("bp_valid_seen", 64'(seen), 64'd1);
        end
        @(posedge clk_24); #1;
        drive_a(3'd4, 32'h1000, 3'd2, 4'd9, 4'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_24);
            check("bp_hold", 64'({bus.d_valid, bus.a_ready}), 64'b10);
        end
        @(posedge clk_24); #1;
        dr_mode = 0;
        begin
            logic got;
            got = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk_24);
                if (bus.a_ready) begin got = 1'b1; break; end
            end
            check("bp_second_accept", 64'(got), 64'd1);
        end
        @(posedge clk_24); #1;
        bus.a_valid = 1'b0;
        check("bp_accept_slot", 64'(acc_cyc), 64'(hs_cyc + 1));
        wait_hs();
        check("bp_second_src", 64'(last_pack[37:34]), 64'd9);

        // Reset during WAIT
        begin
            int hs0;
            hs0 = hs_count;
            send(3'd4, 32'h1000, 3'd2, 4'd2, 4'h0, 32'h0);
            rst_n = 1'b0;
            repeat (3) @(posedge clk_24);
            #1 rst_n = 1'b1;
            repeat (6) @(posedge clk_24);
            #1;
            check("rst_no_resp", 64'(hs_count), 64'(hs0));
        end
        txn(3'd4, 32'h1000, 3'd2, 4'd2, 4'h0, 32'h0);
        check("rst_cleared", 64'(last_pack[32:1]), 64'h0);

        // Random traffic
        dr_mode = 2;
        for (int n = 0; n < 120; n++) begin
            logic [2:0]  op;
            logic [31:0] addr;
            logic [2:0]  sz;
            int r;
            r = $urandom_range(0, 9);
            if (r < 3)      op = 3'd4;
            else if (r < 6) op = 3'd0;
            else if (r < 8) op = 3'd1;
            else            op = 3'($urandom_range(5, 10) % 8);
            addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 7) == 0) addr = 32'h0FE0 + 32'($urandom_range(0, 127));
            sz = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
            txn(op, addr, sz, 4'($urandom), 4'($urandom), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk_24);
        end
        dr_mode = 0;
        repeat (3) @(posedge clk_24);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
